// File: rtl/effect_pkg.sv
// Shared types for the effect crossfade selector: FSM states, one-hot humidity zones
// and the stereo sample word layout {L,R}.
package effect_pkg;

  typedef enum logic [1:0] {
    STEADY  = 2'd0,
    PENDING = 2'd1,
    FADE    = 2'd2
  } sel_state_e;

  // One-hot {high,mid,low}, wired straight to the zone LEDs.
  typedef enum logic [2:0] {
    ZONE_LOW  = 3'b001,
    ZONE_MID  = 3'b010,
    ZONE_HIGH = 3'b100
  } zone_e;

  localparam int SAMPLE_DW = 16;

  typedef struct packed {
    logic signed [SAMPLE_DW-1:0] l;
    logic signed [SAMPLE_DW-1:0] r;
  } sample_t;

endpackage

// File: rtl/xfade_mac.sv
// One-channel crossfade: (old*(2^F-g) + new*g) >>> F with floor rounding.
// With XFADE_SEL_FADE_EN undefined the old stream passes straight through.
module xfade_mac #(
  parameter int DW        = 16,
  parameter int FADE_LOG2 = 8
) (
  input  logic signed [DW-1:0]        old_s,
  input  logic signed [DW-1:0]        new_s,
  input  logic        [FADE_LOG2-1:0] g,
  output logic signed [DW-1:0]        mix
);

`ifdef XFADE_SEL_FADE_EN
  localparam int ACC_W = DW + FADE_LOG2 + 2;
  localparam int WGT_W = FADE_LOG2 + 2;

  // The weights sum to 2^F, so the floored result always lies between old and new.
  function automatic logic signed [DW-1:0] floor_shift(input logic signed [ACC_W-1:0] acc);
    return DW'(acc >>> FADE_LOG2);
  endfunction

  logic signed [WGT_W-1:0] w_new;
  logic signed [WGT_W-1:0] w_old;
  logic signed [ACC_W-1:0] prod_old;
  logic signed [ACC_W-1:0] prod_new;

  assign w_new    = signed'({2'b00, g});
  assign w_old    = signed'(WGT_W'(1 << FADE_LOG2)) - w_new;
  assign prod_old = ACC_W'(old_s) * ACC_W'(w_old);
  assign prod_new = ACC_W'(new_s) * ACC_W'(w_new);
  assign mix      = floor_shift(prod_old + prod_new);
`else
  logic unused_fade_inputs;

  assign unused_fade_inputs = ^{new_s, g};
  assign mix                = old_s;
`endif

endmodule

// File: rtl/effect_xfade_sel.sv
// Selects one of NUM_FX wet streams or dry bypass, manually or by humidity zone with dwell,
// and crossfades between selections. Crossfade is built only with XFADE_SEL_FADE_EN defined.
module effect_xfade_sel
  import effect_pkg::*;
#(
  parameter int NUM_FX    = 3,
  parameter int DW        = 16,
  parameter int HUM_W     = 8,
  parameter int THRESH_LO = 40,
  parameter int THRESH_HI = 70,
  parameter int HYST      = 3,
  parameter int DWELL     = 4800,
  parameter int FADE_LOG2 = 8,
  parameter int FX_LOW    = 1,
  parameter int FX_MID    = 2,
  parameter int FX_HIGH   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [HUM_W-1:0]            humidity,
  input  logic                        manual,
  input  logic [NUM_FX-1:0]           manual_en,
  input  logic [2*DW-1:0]             dry_sample,
  input  logic [NUM_FX*2*DW-1:0]      fx_sample,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [2*DW-1:0]             out_sample,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(NUM_FX+1)-1:0] active_sel,
  output logic                        fading,
  output logic [2:0]                  zone
);

  localparam int SEL_W   = $clog2(NUM_FX + 1);
  localparam int SW      = 2 * DW;
  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SEL_W-1:0]   DRY_SEL    = SEL_W'(NUM_FX);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  localparam int LO_UP = THRESH_LO + HYST;
  localparam int LO_DN = THRESH_LO - HYST;
  localparam int HI_UP = THRESH_HI + HYST;
  localparam int HI_DN = THRESH_HI - HYST;

  typedef struct packed {
    logic signed [DW-1:0] l;
    logic signed [DW-1:0] r;
  } chan_pair_t;

  function automatic logic [SEL_W-1:0] lowest_en(input logic [NUM_FX-1:0] en);
    logic [SEL_W-1:0] idx;
    idx = DRY_SEL;
    for (int i = NUM_FX - 1; i >= 0; i--) begin
      if (en[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [SEL_W-1:0] zone_fx(input zone_e z);
    case (z)
      ZONE_LOW:  return SEL_W'(FX_LOW);
      ZONE_HIGH: return SEL_W'(FX_HIGH);
      default:   return SEL_W'(FX_MID);
    endcase
  endfunction

  sel_state_e       state_q, state_d;
  zone_e            zone_q, zone_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic [SEL_W-1:0] pend_q, pend_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] new_sel;
  logic [FADE_LOG2-1:0] g_mix;
  logic             acc;
  int               hum_i;

`ifdef XFADE_SEL_FADE_EN
  logic [SEL_W-1:0]     new_q, new_d;
  logic [FADE_LOG2-1:0] g_q, g_d;

  assign new_sel = new_q;
  assign g_mix   = g_q;
  assign fading  = (state_q == FADE);
`else
  assign new_sel = active_q;
  assign g_mix   = '0;
  assign fading  = 1'b0;
`endif

  assign in_ready   = !out_valid || out_ready;
  assign acc        = in_valid && in_ready;
  assign hum_i      = int'(humidity);
  assign cand       = manual ? lowest_en(manual_en) : zone_fx(zone_q);
  assign active_sel = active_q;
  assign zone       = zone_q;

  // Hysteresis applies only when leaving the current zone; at most one step per clock.
  always_comb begin
    zone_d = zone_q;
    case (zone_q)
      ZONE_LOW:  if (hum_i >= LO_UP) zone_d = ZONE_MID;
      ZONE_MID: begin
        if (hum_i < LO_DN)      zone_d = ZONE_LOW;
        else if (hum_i > HI_UP) zone_d = ZONE_HIGH;
      end
      ZONE_HIGH: if (hum_i <= HI_DN) zone_d = ZONE_MID;
      default:   zone_d = ZONE_MID;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    pend_d   = pend_q;
    dwell_d  = dwell_q;
`ifdef XFADE_SEL_FADE_EN
    new_d    = new_q;
    g_d      = g_q;
`endif
    case (state_q)
      STEADY: begin
        if (cand != active_q) begin
          if (!manual) begin
            state_d = PENDING;
            pend_d  = cand;
            dwell_d = '0;
          end else if (acc) begin
`ifdef XFADE_SEL_FADE_EN
            state_d = FADE;
            new_d   = cand;
            g_d     = '0;
`else
            active_d = cand;
`endif
          end
        end
      end
      PENDING: begin
        // Switching to manual mid-dwell acts on the same clock, without waiting for a sample.
        if (manual) begin
          if (cand == active_q) begin
            state_d = STEADY;
          end else begin
`ifdef XFADE_SEL_FADE_EN
            state_d = FADE;
            new_d   = cand;
            g_d     = '0;
`else
            state_d  = STEADY;
            active_d = cand;
`endif
          end
        end else if (acc) begin
          if (cand == active_q) begin
            state_d = STEADY;
          end else if (cand != pend_q) begin
            pend_d  = cand;
            dwell_d = '0;
          end else if (dwell_q == DWELL_LAST) begin
`ifdef XFADE_SEL_FADE_EN
            state_d = FADE;
            new_d   = pend_q;
            g_d     = '0;
`else
            state_d  = STEADY;
            active_d = pend_q;
`endif
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
`ifdef XFADE_SEL_FADE_EN
      FADE: begin
        if (acc) begin
          if (g_q == '1) begin
            state_d  = STEADY;
            active_d = new_q;
            g_d      = '0;
          end else begin
            g_d = g_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = STEADY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= STEADY;
      zone_q   <= ZONE_MID;
      active_q <= DRY_SEL;
      pend_q   <= DRY_SEL;
      dwell_q  <= '0;
`ifdef XFADE_SEL_FADE_EN
      new_q    <= DRY_SEL;
      g_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      zone_q   <= zone_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      dwell_q  <= dwell_d;
`ifdef XFADE_SEL_FADE_EN
      new_q    <= new_d;
      g_q      <= g_d;
`endif
    end
  end

  // Stage p0: stream selection and per-channel mix (combinational)
  chan_pair_t old_p0;
  chan_pair_t new_p0;
  logic signed [DW-1:0] mix_l_p0;
  logic signed [DW-1:0] mix_r_p0;

  always_comb begin
    old_p0 = dry_sample;
    new_p0 = dry_sample;
    for (int i = 0; i < NUM_FX; i++) begin
      if (active_q == SEL_W'(i)) old_p0 = fx_sample[i*SW +: SW];
      if (new_sel == SEL_W'(i))  new_p0 = fx_sample[i*SW +: SW];
    end
  end

  xfade_mac #(.DW(DW), .FADE_LOG2(FADE_LOG2)) u_mac_l (
    .old_s (old_p0.l),
    .new_s (new_p0.l),
    .g     (g_mix),
    .mix   (mix_l_p0)
  );

  xfade_mac #(.DW(DW), .FADE_LOG2(FADE_LOG2)) u_mac_r (
    .old_s (old_p0.r),
    .new_s (new_p0.r),
    .g     (g_mix),
    .mix   (mix_r_p0)
  );

  // Stage p1: output register, holds while the downstream FIFO is full
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else if (acc) begin
      out_valid  <= 1'b1;
      out_sample <= {mix_l_p0, mix_r_p0};
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
